// File: rtl/jelly_bean_taster_arbiter.sv
// Round-robin arbiter that shares one jelly-bean taster between NUM_REQ requesters.
// Define JELLY_BEAN_ARB_STATS_EN to add the tx_count / yucky_count statistics outputs.
//
// state | meaning
// IDLE  | arbitrate pending requests, combinational gnt to the winner
// DRIVE | present the latched bean fields to the taster for one cycle
// WAIT  | count down TASTE_LAT-1 cycles, then register jb_taste
// RESP  | pulse resp_valid to the granted requester, advance RR pointer
module jelly_bean_taster_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TASTE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_flavor,
  input  logic [2*NUM_REQ-1:0]   req_color,
  input  logic [NUM_REQ-1:0]     req_sugar_free,
  input  logic [NUM_REQ-1:0]     req_sour,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [1:0]             resp_taste,
  output logic [2:0]             jb_flavor,
  output logic [1:0]             jb_color,
  output logic                   jb_sugar_free,
  output logic                   jb_sour,
  input  logic [1:0]             jb_taste,
  output logic                   busy
`ifdef JELLY_BEAN_ARB_STATS_EN
  ,
  output logic [15:0]            yucky_count,
  output logic [15:0]            tx_count
`endif
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [2:0]        flavor_q, flavor_d;
  logic [1:0]        color_q, color_d;
  logic              sugar_free_q, sugar_free_d;
  logic              sour_q, sour_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        taste_q, taste_d;

  logic              win_found;
  logic [IDXW-1:0]   win_idx;
  logic [IDXW-1:0]   cand_idx;
  int                cand;
  logic [2:0]        sel_flavor;
  logic [1:0]        sel_color;
  logic              sel_sugar_free;
  logic              sel_sour;

  // Scan starting just after the last served requester so it loses any tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_q) + k) % NUM_REQ;
      cand_idx = IDXW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_flavor     = '0;
    sel_color      = '0;
    sel_sugar_free = 1'b0;
    sel_sour       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDXW'(i)) begin
        sel_flavor     = req_flavor[3*i +: 3];
        sel_color      = req_color[2*i +: 2];
        sel_sugar_free = req_sugar_free[i];
        sel_sour       = req_sour[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    flavor_d     = flavor_q;
    color_d      = color_q;
    sugar_free_d = sugar_free_q;
    sour_d       = sour_q;
    cnt_d        = cnt_q;
    taste_d      = taste_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d        = win_idx;
          flavor_d     = sel_flavor;
          color_d      = sel_color;
          sugar_free_d = sel_sugar_free;
          sour_d       = sel_sour;
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = 4'(TASTE_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          taste_d = jb_taste;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_q       <= IDXW'(NUM_REQ - 1);
      flavor_q     <= '0;
      color_q      <= '0;
      sugar_free_q <= 1'b0;
      sour_q       <= 1'b0;
      cnt_q        <= '0;
      taste_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      flavor_q     <= flavor_d;
      color_q      <= color_d;
      sugar_free_q <= sugar_free_d;
      sour_q       <= sour_d;
      cnt_q        <= cnt_d;
      taste_q      <= taste_d;
    end
  end

  assign gnt           = (state_q == IDLE && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
  assign resp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << idx_q) : '0;
  assign resp_taste    = taste_q;
  assign jb_flavor     = (state_q == DRIVE) ? flavor_q : 3'd0;
  assign jb_color      = (state_q == DRIVE) ? color_q : 2'd0;
  assign jb_sugar_free = (state_q == DRIVE) ? sugar_free_q : 1'b0;
  assign jb_sour       = (state_q == DRIVE) ? sour_q : 1'b0;
  assign busy          = (state_q != IDLE);

`ifdef JELLY_BEAN_ARB_STATS_EN
  logic [15:0] tx_cnt_q, yucky_cnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q    <= '0;
      yucky_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
      if (taste_q == 2'd2 && yucky_cnt_q != 16'hFFFF) yucky_cnt_q <= yucky_cnt_q + 16'd1;
    end
  end

  assign tx_count    = tx_cnt_q;
  assign yucky_count = yucky_cnt_q;
`endif

endmodule

// File: tb/tb_jelly_bean_taster_arbiter.sv
// Directed bench for jelly_bean_taster_arbiter: one instance at TASTE_LAT=1, one at TASTE_LAT=3.
// Statistics checks are compiled in when JELLY_BEAN_ARB_STATS_EN is defined.
module tb_jelly_bean_taster_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] req_flavor = '0;
  logic [2*N-1:0] req_color = '0;
  logic [N-1:0]   req_sugar_free = '0;
  logic [N-1:0]   req_sour = '0;
  logic [1:0]     jb_taste = '0;

  logic [N-1:0] gnt, resp_valid, gnt3, resp_valid3;
  logic [1:0]   resp_taste, resp_taste3, jb_color, jb_color3;
  logic [2:0]   jb_flavor, jb_flavor3;
  logic         jb_sugar_free, jb_sour, busy, jb_sugar_free3, jb_sour3, busy3;
`ifdef JELLY_BEAN_ARB_STATS_EN
  logic [15:0]  yucky_count, tx_count, yucky_count3, tx_count3;
`endif

  always #5 clk = ~clk;

  jelly_bean_taster_arbiter #(.NUM_REQ(N), .TASTE_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_flavor(req_flavor), .req_color(req_color),
    .req_sugar_free(req_sugar_free), .req_sour(req_sour), .gnt(gnt), .resp_valid(resp_valid),
    .resp_taste(resp_taste), .jb_flavor(jb_flavor), .jb_color(jb_color),
    .jb_sugar_free(jb_sugar_free), .jb_sour(jb_sour), .jb_taste(jb_taste), .busy(busy)
`ifdef JELLY_BEAN_ARB_STATS_EN
    , .yucky_count(yucky_count), .tx_count(tx_count)
`endif
  );

  jelly_bean_taster_arbiter #(.NUM_REQ(N), .TASTE_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_flavor(req_flavor), .req_color(req_color),
    .req_sugar_free(req_sugar_free), .req_sour(req_sour), .gnt(gnt3), .resp_valid(resp_valid3),
    .resp_taste(resp_taste3), .jb_flavor(jb_flavor3), .jb_color(jb_color3),
    .jb_sugar_free(jb_sugar_free3), .jb_sour(jb_sour3), .jb_taste(jb_taste), .busy(busy3)
`ifdef JELLY_BEAN_ARB_STATS_EN
    , .yucky_count(yucky_count3), .tx_count(tx_count3)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    jb_taste = '0;
    req_flavor = '0;
    req_color = '0;
    req_sugar_free = '0;
    req_sour = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  int seq [4] = '{0, 2, 0, 2};
`ifdef JELLY_BEAN_ARB_STATS_EN
  logic [1:0] tastes [5] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd2};
`endif

  initial begin
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_taste", 32'(resp_taste), 32'h0);
    chk("rst_jb", 32'({jb_flavor, jb_color, jb_sugar_free, jb_sour}), 32'h0);
    do_reset();

    // single request from requester 1
    req        = 4'b0010;
    req_flavor = 12'(3) << 3;
    req_color  = 8'(1) << 2;
    req_sour   = 4'b0010;
    sample();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_busy_idle", 32'(busy), 32'h0);
    tick();
    req = '0;
    sample();
    chk("t1_jb_flavor", 32'(jb_flavor), 32'h3);
    chk("t1_jb_color", 32'(jb_color), 32'h1);
    chk("t1_jb_sour", 32'(jb_sour), 32'h1);
    chk("t1_jb_sugar_free", 32'(jb_sugar_free), 32'h0);
    chk("t1_gnt_busy", 32'(gnt), 32'h0);
    tick();
    jb_taste = 2'd2;
    sample();
    chk("t1_jb_cleared", 32'(jb_flavor), 32'h0);
    chk("t1_rv_early", 32'(resp_valid), 32'h0);
    tick();
    jb_taste = 2'd0;
    sample();
    chk("t1_resp_valid", 32'(resp_valid), 32'h2);
    chk("t1_resp_taste", 32'(resp_taste), 32'h2);
    tick();
    sample();
    chk("t1_rv_pulse", 32'(resp_valid), 32'h0);
    chk("t1_taste_hold", 32'(resp_taste), 32'h2);
    chk("t1_idle", 32'(busy), 32'h0);

    // all four request, each drops after its grant
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      jb_taste = 2'(g);
      sample();
      chk("t2_gnt", 32'(gnt), 32'(1) << g);
      tick();
      req = req & ~(4'b0001 << g);
      tick();
      tick();
      sample();
      chk("t2_resp_valid", 32'(resp_valid), 32'(1) << g);
      chk("t2_resp_taste", 32'(resp_taste), 32'(g));
      tick();
    end

    // requester 0 held continuously alongside requester 2
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t3_gnt", 32'(gnt), 32'(1) << seq[i]);
      tick();
      sample();
      chk("t3_no_gnt_busy", 32'(gnt), 32'h0);
      tick();
      tick();
      sample();
      chk("t3_resp_valid", 32'(resp_valid), 32'(1) << seq[i]);
      tick();
    end

    // reset asserted during WAIT
    do_reset();
    req = 4'b0001;
    sample();
    chk("t4_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_rv", 32'(resp_valid), 32'h0);
    chk("t4_rst_taste", 32'(resp_taste), 32'h0);
    tick();
    sample();
    chk("t4_no_resp", 32'(resp_valid), 32'h0);
    rst_n = 1'b1;
    req = 4'b1001;
    #1;
    chk("t4_gnt_req0_wins", 32'(gnt), 32'h1);
    req = 4'b1000;
    #1;
    chk("t4_gnt_req3", 32'(gnt), 32'h8);

    // TASTE_LAT=3 instance
    do_reset();
    req        = 4'b0001;
    req_flavor = 12'h005;
    sample();
    chk("t5_gnt", 32'(gnt3), 32'h1);
    tick();
    req = '0;
    sample();
    chk("t5_jb_flavor", 32'(jb_flavor3), 32'h5);
    chk("t5_busy", 32'(busy3), 32'h1);
    tick();
    jb_taste = 2'd1;
    sample();
    chk("t5_jb_cleared", 32'(jb_flavor3), 32'h0);
    tick();
    jb_taste = 2'd1;
    tick();
    jb_taste = 2'd2;
    sample();
    chk("t5_rv_early", 32'(resp_valid3), 32'h0);
    tick();
    jb_taste = 2'd0;
    sample();
    chk("t5_resp_valid", 32'(resp_valid3), 32'h1);
    chk("t5_resp_taste", 32'(resp_taste3), 32'h2);

`ifdef JELLY_BEAN_ARB_STATS_EN
    do_reset();
    chk("st_tx_rst", 32'(tx_count), 32'h0);
    chk("st_yucky_rst", 32'(yucky_count), 32'h0);
    for (int i = 0; i < 5; i++) begin
      req = 4'b0001;
      tick();
      req = '0;
      jb_taste = tastes[i];
      tick();
      tick();
      tick();
    end
    sample();
    chk("st_tx_count", 32'(tx_count), 32'd5);
    chk("st_yucky_count", 32'(yucky_count), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jelly_bean_taster_arbiter.md
Name: jelly_bean_taster_arbiter

Overview:
- Shares one jelly-bean taster (the DUT behind the jelly-bean interface) between NUM_REQ requesters.
- Round-robin arbitration; one transaction at a time; routes the taste result back to the granted requester.
- Drives the master side of the interface: flavor, color, sugar_free and sour out; taste in.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TASTE_LAT, 1, cycles from bean-drive cycle to taste sample (1..15)

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request; hold with fields stable until gnt
req_flavor  input  3*NUM_REQ  flavor per requester, slice i = [3i+2:3i]
req_color  input  2*NUM_REQ  color per requester
req_sugar_free  input  NUM_REQ  sugar_free per requester
req_sour  input  NUM_REQ  sour per requester
gnt  output  NUM_REQ  one-hot, combinational, IDLE only; request accepted this cycle
resp_valid  output  NUM_REQ  one-hot 1-cycle pulse: result ready for requester i
resp_taste  output  2  sampled taste, valid with resp_valid
jb_flavor  output  3  to taster
jb_color  output  2  to taster
jb_sugar_free  output  1  to taster
jb_sour  output  1  to taster
jb_taste  input  2  from taster (0 NO_TASTE, 1 YUMMY, 2 YUCKY)
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; jb_* = 0; resp_valid = 0; resp_taste = 0; latched fields = 0; RR pointer last = NUM_REQ-1 (requester 0 wins first); wait counter = 0.
- FSM states: IDLE, DRIVE, WAIT, RESP.
- IDLE: if |req, winner = first set bit scanning last+1, last+2, ... modulo NUM_REQ. gnt[winner] = 1 this cycle; on the edge, latch winner index and its fields -> DRIVE. If no req, stay; gnt = 0.
- DRIVE (1 cycle): jb_* = latched fields; load counter = TASTE_LAT-1 -> WAIT.
- WAIT: jb_* return to 0. If counter == 0, register jb_taste -> RESP; else decrement.
- RESP (1 cycle): resp_valid[idx] = 1; resp_taste = registered taste; last = idx -> IDLE.
- Outside DRIVE, jb_* = 0. Outside RESP, resp_valid = 0; resp_taste holds its last value.
- Latency: gnt at cycle T; DRIVE at T+1; taste sampled on the edge ending cycle T+1+TASTE_LAT; resp_valid at T+2+TASTE_LAT. Turnaround is TASTE_LAT+3 cycles per transaction.
- req changes while busy are ignored; no gnt while busy. A requester still holding req after RESP is rearbitrated in the next IDLE, so it loses to any other pending requester.
- Taste value 3 is passed through unmodified.
- Reset mid-transaction: transaction aborted, no resp_valid, pointer reset.
- Simultaneous req from all: grant order strictly rotates 0,1,...,NUM_REQ-1,0...

Optional Feature:
- Macro JELLY_BEAN_ARB_STATS_EN.
- Defined: adds output yucky_count [15:0] and output tx_count [15:0], both reset to 0.
  - tx_count increments on every RESP.
  - yucky_count increments on RESP when the sampled taste == 2.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- NUM_REQ=4, TASTE_LAT=1: req=4'b0010 with flavor=3, color=1, sour=1 at cycle 0 -> gnt=0010 at cycle 0; jb_flavor=3, jb_color=1, jb_sour=1 at cycle 1 only; taster returns 2 -> resp_valid=0010, resp_taste=2 at cycle 3.
- req=4'b1111 held, with each requester dropping its req after its gnt -> grants in order 0,1,2,3 at cycles 0,4,8,12; each resp_valid matches the grant index.
- req[0] held high continuously together with req[2] -> grants alternate 0,2,0,2; requester 0 never gets two consecutive grants.
- TASTE_LAT=3, single req at cycle 0 -> DRIVE at cycle 1, resp_valid at cycle 5; jb_taste values presented at cycles 2-3 are ignored.
- rst_n pulled low during WAIT -> all outputs 0 immediately, no resp_valid; a new req[3] after release is granted at cycle 0 only if req[0..2] are low.
- STATS_EN: 5 transactions with tastes 1,2,2,0,2 -> tx_count=5, yucky_count=3.
